// File: rtl/product_accumulator.sv
// Sums a run of n unsigned 8-bit products from a 4x4 multiplier.
// The input uses a valid/ready handshake; the result is held until downstream takes it.
//
// state | meaning
// IDLE  | waiting for start; acc keeps the last result
// ACCUM | accepting products; cnt_q counts the transfers still owed
// DONE  | acc holds the final sum; waiting for out_ready
module product_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       n,
  input  logic             in_valid,
  input  logic [7:0]       in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          // An empty run goes straight to DONE with a zero result
          if (n == 4'd0) begin
            state_d = DONE;
          end else begin
            cnt_d   = n;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(in_prod);
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc       = acc_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: expected sums are queued at stimulus
// time and a monitor pops them on each out_valid/out_ready handshake.
module tb_product_accumulator;

  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       n;
  logic             in_valid;
  logic [7:0]       in_prod;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] sb_q[$];

  product_accumulator #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] p);
    check("in_ready_before_xfer", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_prod  = p;
    step();
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: result transfers are compared against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0d required=none at %0t", acc, $time);
        end else begin
          check("result_acc", 32'(acc), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; n = 4'd0;
    in_valid = 1'b0; in_prod = 8'd0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    step();

    // Basic run: 15 + 225 + 6 = 246
    sb_q.push_back(12'd246);
    start = 1'b1; n = 4'd3;
    step();
    start = 1'b0;
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_acc_cleared", 32'(acc), 32'd0);
    send(8'd15);
    send(8'd225);
    send(8'd6);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_in_ready_done", 32'(in_ready), 32'd0);
    check("basic_acc", 32'(acc), 32'd246);
    step();
    check("basic_out_valid_one_cycle", 32'(out_valid), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);
    check("basic_acc_kept", 32'(acc), 32'd246);

    // Bubbles, with a stray start during ACCUM
    sb_q.push_back(12'd30);
    start = 1'b1; n = 4'd2;
    step();
    start = 1'b0;
    send(8'd10);
    for (int i = 0; i < 2; i++) begin
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      check("bubble_acc_hold", 32'(acc), 32'd10);
      start = 1'b1; n = 4'd9;
      step();
    end
    start = 1'b0;
    send(8'd20);
    check("bubble_out_valid", 32'(out_valid), 32'd1);
    check("bubble_acc", 32'(acc), 32'd30);
    step();
    check("bubble_idle", 32'(busy), 32'd0);

    // Maximum run under back-pressure: 15 * 225 = 3375
    out_ready = 1'b0;
    sb_q.push_back(12'd3375);
    start = 1'b1; n = 4'd15;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) send(8'd225);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_acc", 32'(acc), 32'd3375);
      if (i >= 2) begin
        start = 1'b1; n = 4'd9;
      end
      step();
    end
    check("bp_still_done", 32'(out_valid), 32'd1);
    out_ready = 1'b1;   // start still high during the handshake
    step();
    start = 1'b0;
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_acc_kept", 32'(acc), 32'd3375);
    step();
    check("bp_start_on_handshake_ignored", 32'(busy), 32'd0);

    // Empty run
    sb_q.push_back(12'd0);
    start = 1'b1; n = 4'd0;
    step();
    start = 1'b0;
    check("empty_out_valid", 32'(out_valid), 32'd1);
    check("empty_acc", 32'(acc), 32'd0);
    check("empty_in_ready", 32'(in_ready), 32'd0);
    step();
    check("empty_idle", 32'(busy), 32'd0);

    // Reset mid-run after 2 of 4 products
    start = 1'b1; n = 4'd4;
    step();
    start = 1'b0;
    send(8'd50);
    send(8'd60);
    check("midrun_acc", 32'(acc), 32'd110);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_acc", 32'(acc), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b0;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);
    sb_q.push_back(12'd7);
    start = 1'b1; n = 4'd1;
    step();
    start = 1'b0;
    send(8'd7);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_acc", 32'(acc), 32'd7);
    step();
    step();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
